c3_heap_issue_ctrl: RTL and testbench

- Upstream issue stage for the C3 heap custom-instruction engine.
- Accepts heap commands (push/pop/peek/clear) from the core's custom-instruction decode, buffers them in a small FIFO, and issues them to the multi-cycle heap engine one at a time.
- Tracks heap occupancy locally so that illegal ops (push-full, pop-empty) are rejected without reaching the engine.
- Returns a tagged result (rd, data, err) to writeback through a valid/ready handshake.

---
 rtl/c3_heap_pkg.sv | 35 +++
 rtl/c3_heap_issue_ctrl_if.sv | 40 ++++
 rtl/c3_cmd_fifo.sv | 65 ++++++
 rtl/c3_heap_issue_ctrl.sv | 125 ++++++++++++
 tb/tb_c3_heap_issue_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/c3_heap_pkg.sv
// Shared definitions for the C3 heap custom-instruction path: op codes,
// issue-controller FSM states, the queued command record and the legality rule.
package c3_heap_pkg;

    localparam int DEFAULT_HEAP_SIZE = 25;

    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_POP   = 2'd1;
    localparam logic [1:0] OP_PEEK  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } issue_state_e;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] rd;
        logic [7:0] data;
    } heap_cmd_t;

    localparam int CMD_W = $bits(heap_cmd_t);

    // Ops the engine must never see: push into a full heap, pop/peek of an empty one.
    function automatic logic cmd_illegal(input logic [1:0] op,
                                         input logic heap_empty,
                                         input logic heap_full);
        return ((op == OP_PUSH) && heap_full) ||
               (((op == OP_POP) || (op == OP_PEEK)) && heap_empty);
    endfunction

endpackage

// File: rtl/c3_heap_issue_ctrl_if.sv
// Command, engine and response handshakes of the heap issue controller.
// The controller takes the slave modport; core/engine/writeback side takes master.
interface c3_heap_issue_ctrl_if;

    logic        cmd_v;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_rd;
    logic [31:0] cmd_data;

    logic        eng_v;
    logic [1:0]  eng_op;
    logic [7:0]  eng_data;
    logic        eng_ready;
    logic        eng_done;
    logic [7:0]  eng_rdata;

    logic        rsp_v;
    logic        rsp_ready;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_v, cmd_op, cmd_rd, cmd_data,
        output eng_ready, eng_done, eng_rdata,
        output rsp_ready,
        input  cmd_ready, eng_v, eng_op, eng_data,
        input  rsp_v, rsp_rd, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_v, cmd_op, cmd_rd, cmd_data,
        input  eng_ready, eng_done, eng_rdata,
        input  rsp_ready,
        output cmd_ready, eng_v, eng_op, eng_data,
        output rsp_v, rsp_rd, rsp_data, rsp_err
    );

endinterface

// File: rtl/c3_cmd_fifo.sv
// Synchronous FIFO with registered occupancy count; full/empty come straight
// from the count so there is no combinational path from the read side to full.
module c3_cmd_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        // Power-of-two depth lets the pointers wrap by plain overflow.
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count gates every read, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/c3_heap_issue_ctrl.sv
// Issue stage for the C3 heap engine: queues commands, rejects illegal ops
// against a locally tracked occupancy, and issues legal ones one at a time.
module c3_heap_issue_ctrl
    import c3_heap_pkg::*;
#(
    parameter int HEAP_SIZE = DEFAULT_HEAP_SIZE,
    parameter int CQ_DEPTH  = 4,
    parameter int OCC_W     = $clog2(HEAP_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    c3_heap_issue_ctrl_if.slave  bus,
    output logic [OCC_W-1:0]     occupancy
);

    issue_state_e     state_q, state_d;
    heap_cmd_t        hold_q, hold_d;
    logic [4:0]       rsp_rd_q, rsp_rd_d;
    logic [7:0]       rsp_val_q, rsp_val_d;
    logic             rsp_err_q, rsp_err_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    heap_cmd_t        cmd_in;
    heap_cmd_t        fifo_head;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic             head_illegal;
    logic             unused_cmd_hi;

    assign cmd_in        = '{op: bus.cmd_op, rd: bus.cmd_rd, data: bus.cmd_data[7:0]};
    assign unused_cmd_hi = ^bus.cmd_data[31:8];

    c3_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CQ_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.cmd_v),
        .wdata (cmd_in),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .empty (fifo_empty)
    );

    assign head_illegal = cmd_illegal(fifo_head.op, occ_q == '0,
                                      occ_q == OCC_W'(HEAP_SIZE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = head_illegal ? ST_RESP : ST_ISSUE;
            ST_ISSUE: if (bus.eng_ready) state_d = ST_WAIT;
            ST_WAIT:  if (bus.eng_done) state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop      = (state_q == ST_IDLE) && !fifo_empty;
        bus.eng_v     = (state_q == ST_ISSUE);
        bus.rsp_v     = (state_q == ST_RESP);
        bus.cmd_ready = !fifo_full;
        bus.eng_op    = hold_q.op;
        bus.eng_data  = hold_q.data;
        bus.rsp_rd    = rsp_rd_q;
        bus.rsp_data  = {24'd0, rsp_val_q};
        bus.rsp_err   = rsp_err_q;
        occupancy     = occ_q;
    end

    // Datapath: latch the popped command, build the response, track occupancy.
    always_comb begin
        hold_d    = hold_q;
        rsp_rd_d  = rsp_rd_q;
        rsp_val_d = rsp_val_q;
        rsp_err_d = rsp_err_q;
        occ_d     = occ_q;
        if ((state_q == ST_IDLE) && !fifo_empty) begin
            hold_d = fifo_head;
            if (head_illegal) begin
                rsp_rd_d  = fifo_head.rd;
                rsp_val_d = '0;
                rsp_err_d = 1'b1;
            end
        end
        if ((state_q == ST_WAIT) && bus.eng_done) begin
            rsp_rd_d  = hold_q.rd;
            rsp_err_d = 1'b0;
            rsp_val_d = ((hold_q.op == OP_POP) || (hold_q.op == OP_PEEK)) ? bus.eng_rdata : '0;
            case (hold_q.op)
                OP_PUSH:  occ_d = occ_q + OCC_W'(1);
                OP_POP:   occ_d = occ_q - OCC_W'(1);
                OP_CLEAR: occ_d = '0;
                default:  occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q    <= '0;
            rsp_rd_q  <= '0;
            rsp_val_q <= '0;
            rsp_err_q <= 1'b0;
            occ_q     <= '0;
        end else begin
            hold_q    <= hold_d;
            rsp_rd_q  <= rsp_rd_d;
            rsp_val_q <= rsp_val_d;
            rsp_err_q <= rsp_err_d;
            occ_q     <= occ_d;
        end
    end

endmodule

// File: tb/tb_c3_heap_issue_ctrl.sv
// Self-checking bench for c3_heap_issue_ctrl: directed steps plus a random
// phase, scored against a max-heap reference model and a behavioural engine.
module tb_c3_heap_issue_ctrl;
    import c3_heap_pkg::*;

    localparam int HEAP_SIZE = 25;
    localparam int CQ_DEPTH  = 4;
    localparam int OCC_W     = $clog2(HEAP_SIZE + 1);

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [OCC_W-1:0] occupancy;

    c3_heap_issue_ctrl_if bus ();

    c3_heap_issue_ctrl #(
        .HEAP_SIZE (HEAP_SIZE),
        .CQ_DEPTH  (CQ_DEPTH),
        .OCC_W     (OCC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    rsp_t exp_q[$];
    int   m_heap[$];
    int   m_occ = 0;
    int   exp_issue_cnt = 0;
    int   eng_issue_cnt = 0;
    int   exp_rsp_total = 0;
    int   rsp_cnt = 0;
    int   eng_lat = 4;
    bit   eng_stall = 0, eng_rand = 0, rsp_stall = 0, rsp_rand = 0, inject_done = 0;
    int   eng_heap[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: max-heap semantics, legality from the tracked size.
    task automatic model_accept(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] data);
        rsp_t e;
        int   idx;
        e.rd = rd; e.data = 32'd0; e.err = 1'b0;
        idx = 0;
        for (int i = 1; i < m_heap.size(); i++) if (m_heap[i] > m_heap[idx]) idx = i;
        case (op)
            OP_PUSH: begin
                if (m_occ == HEAP_SIZE) e.err = 1'b1;
                else begin m_occ++; m_heap.push_back(int'(data[7:0])); exp_issue_cnt++; end
            end
            OP_POP, OP_PEEK: begin
                if (m_occ == 0) e.err = 1'b1;
                else begin
                    e.data = 32'(m_heap[idx]);
                    if (op == OP_POP) begin m_heap.delete(idx); m_occ--; end
                    exp_issue_cnt++;
                end
            end
            default: begin m_occ = 0; m_heap.delete(); exp_issue_cnt++; end
        endcase
        exp_q.push_back(e);
        exp_rsp_total++;
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] data);
        int budget = 2000;
        bus.cmd_v = 1'b1; bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_data = data;
        while (bus.cmd_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("cmd_accept_in_time", budget > 0, 1);
        if (budget > 0) model_accept(op, rd, data);
        @(negedge clk);
        bus.cmd_v = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget = 4000;
        while ((exp_q.size() != 0 || bus.rsp_v === 1'b1) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_drain_in_time"}, budget > 0, 1);
        @(negedge clk);
        check({tag, "_occupancy"}, 32'(occupancy), 32'(m_occ));
    endtask

    // Behavioural max-heap engine; it shares the controller reset.
    initial begin : engine_model
        int cnt;
        bit busy;
        int pend;
        int idx;
        cnt = 0; busy = 0; pend = 0;
        bus.eng_ready = 1'b1; bus.eng_done = 1'b0; bus.eng_rdata = 8'd0;
        forever begin
            @(negedge clk);
            bus.eng_done = 1'b0;
            if (reset !== 1'b1) begin
                busy = 0;
                eng_heap.delete();
                bus.eng_ready = 1'b1;
            end else if (inject_done) begin
                inject_done = 0;
                bus.eng_done = 1'b1;
                bus.eng_rdata = 8'hAA;
            end else if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    bus.eng_done = 1'b1;
                    bus.eng_rdata = 8'(pend);
                    busy = 0;
                end
            end else begin
                bus.eng_ready = !eng_stall && (!eng_rand || $urandom_range(0, 2) != 0);
                if (bus.eng_v === 1'b1 && bus.eng_ready) begin
                    eng_issue_cnt++;
                    pend = 0;
                    idx = 0;
                    for (int i = 1; i < eng_heap.size(); i++) if (eng_heap[i] > eng_heap[idx]) idx = i;
                    case (bus.eng_op)
                        OP_PUSH: eng_heap.push_back(int'(bus.eng_data));
                        OP_POP, OP_PEEK: begin
                            if (eng_heap.size() != 0) begin
                                pend = eng_heap[idx];
                                if (bus.eng_op == OP_POP) eng_heap.delete(idx);
                            end
                        end
                        default: eng_heap.delete();
                    endcase
                    cnt = eng_rand ? int'($urandom_range(1, 6)) : eng_lat;
                    busy = 1;
                end
            end
        end
    end

    initial begin : rsp_monitor
        rsp_t e;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.rsp_ready = !rsp_stall && (!rsp_rand || $urandom_range(0, 3) != 0);
            if (reset === 1'b1 && bus.rsp_v === 1'b1 && bus.rsp_ready) begin
                check("rsp_was_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_rd", 32'(bus.rsp_rd), 32'(e.rd));
                    check("rsp_data", bus.rsp_data, e.data);
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    rsp_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] hold_data;
        reset = 1'b0;
        bus.cmd_v = 1'b0; bus.cmd_op = 2'd0; bus.cmd_rd = 5'd0; bus.cmd_data = 32'd0;
        repeat (3) @(negedge clk);

        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_eng_v", 32'(bus.eng_v), 0);
        check("rst_rsp_v", 32'(bus.rsp_v), 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_occupancy", 32'(occupancy), 0);
        reset = 1'b1;
        @(negedge clk);

        // Illegal POP on an empty heap: answered at T+2, engine untouched.
        send(OP_POP, 5'd7, $urandom);
        check("pop_empty_t1_rsp_v", 32'(bus.rsp_v), 0);
        @(negedge clk);
        check("pop_empty_t2_rsp_v", 32'(bus.rsp_v), 1);
        check("pop_empty_t2_err", 32'(bus.rsp_err), 1);
        check("pop_empty_t2_rd", 32'(bus.rsp_rd), 7);
        check("pop_empty_t2_eng_v", 32'(bus.eng_v), 0);
        drain("pop_empty");
        check("pop_empty_issues", 32'(eng_issue_cnt), 32'(exp_issue_cnt));

        // PUSH 0x05: eng_v appears at T+2 with the pushed byte.
        send(OP_PUSH, 5'd3, 32'hDEAD_BE05);
        check("push_t1_eng_v", 32'(bus.eng_v), 0);
        @(negedge clk);
        check("push_t2_eng_v", 32'(bus.eng_v), 1);
        check("push_t2_eng_op", 32'(bus.eng_op), 32'(OP_PUSH));
        check("push_t2_eng_data", 32'(bus.eng_data), 32'h05);
        drain("push1");

        // PEEK/POP return the current maximum, in command order.
        send(OP_CLEAR, 5'd1, 32'd0);
        send(OP_PUSH, 5'd1, 32'h10);
        send(OP_PUSH, 5'd1, 32'h30);
        send(OP_PEEK, 5'd2, 32'd0);
        send(OP_POP, 5'd4, 32'd0);
        drain("peek_pop");

        // Both stalls: holding reg plus CQ_DEPTH entries are accepted, then cmd_ready drops.
        eng_stall = 1; rsp_stall = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) send(OP_PUSH, 5'(10 + i), $urandom);
        check("stall_cmd_ready_low", 32'(bus.cmd_ready), 0);
        hold_data = $urandom;
        bus.cmd_v = 1'b1; bus.cmd_op = OP_PUSH; bus.cmd_rd = 5'd15; bus.cmd_data = hold_data;
        repeat (4) @(negedge clk);
        check("stall_cmd_ready_held", 32'(bus.cmd_ready), 0);
        check("stall_eng_v_held", 32'(bus.eng_v), 1);
        check("stall_no_issue", 32'(eng_issue_cnt), 32'(exp_issue_cnt - 5));
        eng_stall = 0; rsp_stall = 0;
        send(OP_PUSH, 5'd15, hold_data);
        drain("stall");

        // Fill to capacity; the 26th PUSH is rejected without reaching the engine.
        eng_lat = 1;
        send(OP_CLEAR, 5'd0, 32'd0);
        for (int i = 0; i < HEAP_SIZE; i++) send(OP_PUSH, 5'(i), $urandom);
        drain("fill");
        send(OP_PUSH, 5'd26, $urandom);
        @(negedge clk);
        check("full_t2_rsp_v", 32'(bus.rsp_v), 1);
        check("full_t2_err", 32'(bus.rsp_err), 1);
        check("full_t2_eng_v", 32'(bus.eng_v), 0);
        drain("full_reject");
        check("full_issues", 32'(eng_issue_cnt), 32'(exp_issue_cnt));
        send(OP_CLEAR, 5'd27, 32'd0);
        drain("clear");
        send(OP_PUSH, 5'd28, 32'h7F);
        drain("push_after_clear");

        // Reset while WAITing with two queued commands.
        eng_lat = 40;
        for (int i = 0; i < 3; i++) send(OP_PUSH, 5'(20 + i), $urandom);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("midrst_eng_v", 32'(bus.eng_v), 0);
        check("midrst_eng_op_data", {22'd0, bus.eng_op, bus.eng_data}, 0);
        check("midrst_rsp", {bus.rsp_v, bus.rsp_err, 25'd0, bus.rsp_rd}, 0);
        check("midrst_rsp_data", bus.rsp_data, 0);
        check("midrst_occupancy", 32'(occupancy), 0);
        exp_rsp_total -= exp_q.size();
        exp_q.delete(); m_heap.delete(); m_occ = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_issue_cnt = eng_issue_cnt;
        inject_done = 1;
        repeat (4) @(negedge clk);
        check("late_done_rsp_v", 32'(bus.rsp_v), 0);
        check("late_done_eng_v", 32'(bus.eng_v), 0);
        check("late_done_occupancy", 32'(occupancy), 0);
        eng_lat = 4;
        send(OP_PUSH, 5'd30, 32'h42);
        drain("post_reset");

        // Random traffic with random engine latency and writeback backpressure.
        eng_rand = 1; rsp_rand = 1;
        for (int i = 0; i < 60; i++) begin
            int r;
            logic [1:0] op;
            r = int'($urandom_range(0, 9));
            op = (r < 5) ? OP_PUSH : (r < 7) ? OP_POP : (r < 9) ? OP_PEEK : OP_CLEAR;
            send(op, 5'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain("random");
        check("random_issues", 32'(eng_issue_cnt), 32'(exp_issue_cnt));
        check("rsp_total", 32'(rsp_cnt), 32'(exp_rsp_total));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
